// File: rtl/capture_sequencer.sv
// capture_sequencer: arm/trigger/stop/full sequencing, banked write strobes and per-bank depth report.
// Optional macro CAPTURE_SEQ_AUTO_REARM_EN: after readout, HOLD returns to ARMED keeping the banking mode.
package rx_pkg;
  localparam int CHANNELS = 8;
endpackage

module capture_sequencer #(
  parameter int BUFFER_DEPTH = 64,
  parameter int CHANNELS     = rx_pkg::CHANNELS,
  parameter int BMW          = $clog2($clog2(CHANNELS + 1))
) (
  input  logic                                         adc_clk,
  input  logic                                         adc_reset,
  input  logic                                         arm,
  input  logic [BMW-1:0]                               banking_mode,
  input  logic                                         sw_reset,
  input  logic                                         hw_start,
  input  logic                                         hw_stop,
  input  logic                                         sample_valid,
  output logic [CHANNELS-1:0]                          bank_wr_en,
  output logic [CHANNELS*$clog2(BUFFER_DEPTH)-1:0]     bank_wr_addr,
  output logic                                         capture_full,
  output logic [CHANNELS*($clog2(BUFFER_DEPTH)+1)-1:0] write_depth_data,
  output logic                                         write_depth_valid,
  input  logic                                         write_depth_ready,
  input  logic                                         readout_done,
  output logic [1:0]                                   state
);

  localparam int AW     = $clog2(BUFFER_DEPTH);
  localparam int DW     = AW + 1;
  localparam int PW     = $clog2(BUFFER_DEPTH * CHANNELS) + 1;
  localparam int LOG_CH = $clog2(CHANNELS);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  localparam logic [BMW-1:0] MODE_MAX = BMW'(LOG_CH);

  logic [1:0]             state_q, state_d;
  logic [BMW-1:0]         mode_q, mode_d;
  logic [PW-1:0]          p_q, p_d;
  logic                   full_q, full_d;
  logic [CHANNELS-1:0]    wr_en_q, wr_en_d;
  logic [CHANNELS*AW-1:0] wr_addr_q, wr_addr_d;
  logic                   wd_valid_q, wd_valid_d;
  logic [CHANNELS*DW-1:0] wd_data_q, wd_data_d;
  logic                   xfer_done_q, xfer_done_d;
  logic [PW-1:0]          cap_w;
  logic [BMW-1:0]         mode_in;
  logic                   enter_hold;

  // Bank b holds the samples of group k=b>>m, i.e. pointer range [k*DEPTH, (k+1)*DEPTH).
  function automatic logic [DW-1:0] depth_of(input int b, input logic [BMW-1:0] m,
                                             input logic [PW-1:0] p);
    logic [PW-1:0] base;
    logic [PW-1:0] diff;
    base = PW'(b >> m) << AW;
    if (p <= base) return '0;
    diff = p - base;
    if (diff >= PW'(BUFFER_DEPTH)) return DW'(BUFFER_DEPTH);
    return diff[DW-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    p_d         = p_q;
    full_d      = full_q;
    wr_en_d     = '0;
    wr_addr_d   = wr_addr_q;
    wd_valid_d  = wd_valid_q;
    wd_data_d   = wd_data_q;
    xfer_done_d = xfer_done_q;
    enter_hold  = 1'b0;
    cap_w       = PW'(BUFFER_DEPTH * CHANNELS) >> mode_q;
    mode_in     = (banking_mode > MODE_MAX) ? MODE_MAX : banking_mode;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_ARMED;
          mode_d  = mode_in;
          p_d     = '0;
        end
      end
      S_ARMED: begin
        if (hw_start) begin
          if (hw_stop) begin
            state_d    = S_HOLD;
            enter_hold = 1'b1;
          end else begin
            state_d = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        if (hw_stop) begin
          state_d    = S_HOLD;
          enter_hold = 1'b1;
        end else if (sample_valid) begin
          for (int b = 0; b < CHANNELS; b++) begin
            if (PW'(b >> mode_q) == (p_q >> AW)) begin
              wr_en_d[b]             = 1'b1;
              wr_addr_d[b*AW +: AW]  = p_q[AW-1:0];
            end
          end
          p_d = p_q + PW'(1);
          if (p_d == cap_w) begin
            state_d    = S_HOLD;
            full_d     = 1'b1;
            enter_hold = 1'b1;
          end
        end
      end
      default: begin
        if (wd_valid_q && write_depth_ready) begin
          wd_valid_d  = 1'b0;
          xfer_done_d = 1'b1;
        end else if (xfer_done_q && readout_done) begin
`ifdef CAPTURE_SEQ_AUTO_REARM_EN
          state_d = S_ARMED;
`else
          state_d = S_IDLE;
`endif
          full_d      = 1'b0;
          p_d         = '0;
          xfer_done_d = 1'b0;
        end
      end
    endcase

    if (enter_hold) begin
      wd_valid_d  = 1'b1;
      xfer_done_d = 1'b0;
      for (int b = 0; b < CHANNELS; b++) begin
        wd_data_d[b*DW +: DW] = depth_of(b, mode_q, p_d);
      end
    end

    // Software abort outranks everything, including a same-cycle arm or transfer.
    if (sw_reset) begin
      state_d     = S_IDLE;
      p_d         = '0;
      full_d      = 1'b0;
      wr_en_d     = '0;
      wd_valid_d  = 1'b0;
      xfer_done_d = 1'b0;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (adc_reset) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      p_q         <= '0;
      full_q      <= 1'b0;
      wr_en_q     <= '0;
      wr_addr_q   <= '0;
      wd_valid_q  <= 1'b0;
      wd_data_q   <= '0;
      xfer_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      p_q         <= p_d;
      full_q      <= full_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wd_valid_q  <= wd_valid_d;
      wd_data_q   <= wd_data_d;
      xfer_done_q <= xfer_done_d;
    end
  end

  assign state             = state_q;
  assign bank_wr_en        = wr_en_q;
  assign bank_wr_addr      = wr_addr_q;
  assign capture_full      = full_q;
  assign write_depth_valid = wd_valid_q;
  assign write_depth_data  = wd_data_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomized bench for capture_sequencer; expectations come from a sample-level model of the banking rules.
module tb_capture_sequencer;
  localparam int CH  = 8;
  localparam int BD  = 64;
  localparam int AW  = 6;
  localparam int DW  = 7;
  localparam int BMW = 2;
  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_CAPTURE = 2'd2, S_HOLD = 2'd3;
`ifdef CAPTURE_SEQ_AUTO_REARM_EN
  localparam logic [1:0] S_AFTER = S_ARMED;
`else
  localparam logic [1:0] S_AFTER = S_IDLE;
`endif

  logic clk = 1'b0;
  logic adc_reset, arm, sw_reset, hw_start, hw_stop, sample_valid;
  logic write_depth_ready, readout_done;
  logic [BMW-1:0] banking_mode;
  logic [CH-1:0] bank_wr_en;
  logic [CH*AW-1:0] bank_wr_addr;
  logic capture_full, write_depth_valid;
  logic [CH*DW-1:0] write_depth_data;
  logic [1:0] state;

  int n_checks = 0;
  int n_pass   = 0;
  int xfer_cnt = 0;
  int exp_depth[CH];
  bit exp_full;

  capture_sequencer #(.BUFFER_DEPTH(BD), .CHANNELS(CH)) dut (
    .adc_clk(clk), .adc_reset(adc_reset), .arm(arm), .banking_mode(banking_mode),
    .sw_reset(sw_reset), .hw_start(hw_start), .hw_stop(hw_stop), .sample_valid(sample_valid),
    .bank_wr_en(bank_wr_en), .bank_wr_addr(bank_wr_addr), .capture_full(capture_full),
    .write_depth_data(write_depth_data), .write_depth_valid(write_depth_valid),
    .write_depth_ready(write_depth_ready), .readout_done(readout_done), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (write_depth_valid && write_depth_ready) xfer_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Sample i of a capture in mode m lands in banks c + (i/BD)<<m for every active channel c.
  function automatic logic [CH-1:0] exp_mask(input int m, input int i);
    logic [CH-1:0] v;
    v = '0;
    for (int c = 0; c < (1 << m); c++) v[c + ((i / BD) << m)] = 1'b1;
    return v;
  endfunction

  function automatic logic [CH*DW-1:0] exp_depth_vec();
    logic [CH*DW-1:0] v;
    for (int b = 0; b < CH; b++) v[b*DW +: DW] = DW'(exp_depth[b]);
    return v;
  endfunction

  // end_kind: 0 = finish with hw_stop, 1 = finish with sw_reset
  task automatic run_capture(input int m, input int n, input bit do_arm, input int end_kind);
    int cap, cnt, guard, ea;
    bit fin, v;
    logic [CH-1:0] em;
    cap = BD * (CH >> m);
    for (int b = 0; b < CH; b++) exp_depth[b] = 0;
    if (do_arm) begin
      if (state != S_IDLE) begin
        sw_reset = 1'b1; @(negedge clk); sw_reset = 1'b0;
      end
      banking_mode = m[BMW-1:0]; arm = 1'b1;
      @(negedge clk);
      arm = 1'b0; banking_mode = '0;
      n_checks++; if (state !== S_ARMED) $display("FAIL arm_state: got %0d expected %0d", state, S_ARMED); else n_pass++;
    end
    hw_start = 1'b1; sample_valid = 1'b1;
    @(negedge clk);
    hw_start = 1'b0; sample_valid = 1'b0;
    n_checks++; if (state !== S_CAPTURE) $display("FAIL start_state: got %0d expected %0d", state, S_CAPTURE); else n_pass++;
    n_checks++; if (bank_wr_en !== '0) $display("FAIL start_cycle_write: got %0h expected 0", bank_wr_en); else n_pass++;
    cnt = 0; fin = 1'b0; guard = 0;
    while (!fin && guard < 5000) begin
      em = '0; ea = cnt % BD;
      if (cnt < n && cnt < cap) begin
        v = ($urandom_range(0, 3) != 0);
        sample_valid = v;
        if (v) begin
          em = exp_mask(m, cnt);
          for (int b = 0; b < CH; b++) if (em[b]) exp_depth[b]++;
          cnt++;
          if (cnt == cap) fin = 1'b1;
        end
      end else begin
        sample_valid = 1'b1;
        if (end_kind == 1) sw_reset = 1'b1; else hw_stop = 1'b1;
        fin = 1'b1;
      end
      @(negedge clk);
      sample_valid = 1'b0; hw_stop = 1'b0; sw_reset = 1'b0; guard++;
      n_checks++; if (bank_wr_en !== em) $display("FAIL wr_en: got %0h expected %0h", bank_wr_en, em); else n_pass++;
      for (int b = 0; b < CH; b++) if (em[b]) begin
        n_checks++;
        if (bank_wr_addr[b*AW +: AW] !== AW'(ea))
          $display("FAIL wr_addr bank %0d: got %0d expected %0d", b, bank_wr_addr[b*AW +: AW], ea);
        else n_pass++;
      end
    end
    if (guard >= 5000) begin n_checks++; $display("FAIL capture_timeout: got %0d cycles expected fewer", guard); end
    exp_full = (cnt == cap);
    if (end_kind == 1) for (int b = 0; b < CH; b++) exp_depth[b] = 0;
  endtask

  task automatic handshake(input int delay);
    int x0;
    x0 = xfer_cnt;
    for (int i = 0; i < delay; i++) begin
      readout_done = 1'($urandom_range(0, 1)); hw_start = 1'($urandom_range(0, 1));
      @(negedge clk);
      readout_done = 1'b0; hw_start = 1'b0;
      n_checks++; if (write_depth_valid !== 1'b1) $display("FAIL hs_valid_stable: got %0b expected 1", write_depth_valid); else n_pass++;
      n_checks++; if (write_depth_data !== exp_depth_vec()) $display("FAIL hs_data_stable: got %0h expected %0h", write_depth_data, exp_depth_vec()); else n_pass++;
      n_checks++; if (state !== S_HOLD) $display("FAIL hs_state_hold: got %0d expected %0d", state, S_HOLD); else n_pass++;
    end
    write_depth_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (write_depth_valid !== 1'b0) $display("FAIL hs_valid_drop: got %0b expected 0", write_depth_valid); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (xfer_cnt !== x0 + 1) $display("FAIL hs_one_transfer: got %0d expected %0d", xfer_cnt - x0, 1); else n_pass++;
    readout_done = 1'b1;
    @(negedge clk);
    readout_done = 1'b0; write_depth_ready = 1'b0;
    n_checks++; if (state !== S_AFTER) $display("FAIL hs_after_state: got %0d expected %0d", state, S_AFTER); else n_pass++;
    n_checks++; if (capture_full !== 1'b0) $display("FAIL hs_full_clear: got %0b expected 0", capture_full); else n_pass++;
  endtask

  task automatic test_reset();
    adc_reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (state !== S_IDLE) $display("FAIL rst_state: got %0d expected 0", state); else n_pass++;
    n_checks++; if (bank_wr_en !== '0) $display("FAIL rst_wr_en: got %0h expected 0", bank_wr_en); else n_pass++;
    n_checks++; if (bank_wr_addr !== '0) $display("FAIL rst_wr_addr: got %0h expected 0", bank_wr_addr); else n_pass++;
    n_checks++; if (capture_full !== 1'b0) $display("FAIL rst_full: got %0b expected 0", capture_full); else n_pass++;
    n_checks++; if (write_depth_valid !== 1'b0) $display("FAIL rst_valid: got %0b expected 0", write_depth_valid); else n_pass++;
    n_checks++; if (write_depth_data !== '0) $display("FAIL rst_data: got %0h expected 0", write_depth_data); else n_pass++;
    adc_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_without_arm();
    for (int i = 0; i < 4; i++) begin
      hw_start = 1'b1; sample_valid = 1'b1;
      hw_stop = 1'($urandom_range(0, 1)); readout_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      hw_start = 1'b0; sample_valid = 1'b0; hw_stop = 1'b0; readout_done = 1'b0;
      n_checks++; if (state !== S_IDLE) $display("FAIL noarm_state: got %0d expected 0", state); else n_pass++;
      n_checks++; if (bank_wr_en !== '0) $display("FAIL noarm_wr_en: got %0h expected 0", bank_wr_en); else n_pass++;
      n_checks++; if (write_depth_valid !== 1'b0) $display("FAIL noarm_valid: got %0b expected 0", write_depth_valid); else n_pass++;
    end
  endtask

  task automatic test_mode0_stop();
    run_capture(0, 50, 1'b1, 0);
    n_checks++; if (state !== S_HOLD) $display("FAIL m0_state: got %0d expected 3", state); else n_pass++;
    n_checks++; if (capture_full !== 1'b0) $display("FAIL m0_full: got %0b expected 0", capture_full); else n_pass++;
    n_checks++; if (write_depth_valid !== 1'b1) $display("FAIL m0_valid: got %0b expected 1", write_depth_valid); else n_pass++;
    n_checks++; if (write_depth_data !== {{(CH-1)*DW{1'b0}}, 7'd50}) $display("FAIL m0_depth: got %0h expected %0h", write_depth_data, 7'd50); else n_pass++;
    handshake(20);
  endtask

  task automatic test_back_to_back();
`ifdef CAPTURE_SEQ_AUTO_REARM_EN
    run_capture(0, 30, 1'b0, 0);
    n_checks++; if (write_depth_data !== exp_depth_vec()) $display("FAIL rearm_depth: got %0h expected %0h", write_depth_data, exp_depth_vec()); else n_pass++;
    handshake(1);
`else
    hw_start = 1'b1; sample_valid = 1'b1;
    @(negedge clk);
    hw_start = 1'b0; sample_valid = 1'b0;
    n_checks++; if (state !== S_IDLE) $display("FAIL norearm_state: got %0d expected 0", state); else n_pass++;
    @(negedge clk);
    n_checks++; if (bank_wr_en !== '0) $display("FAIL norearm_wr_en: got %0h expected 0", bank_wr_en); else n_pass++;
`endif
  endtask

  task automatic test_mode3_full();
    run_capture(3, 100000, 1'b1, 0);
    n_checks++; if (capture_full !== 1'b1 || !exp_full) $display("FAIL m3_full: got %0b expected 1", capture_full); else n_pass++;
    n_checks++; if (write_depth_data !== exp_depth_vec()) $display("FAIL m3_depth: got %0h expected %0h", write_depth_data, exp_depth_vec()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1; hw_start = 1'b1; hw_stop = 1'($urandom_range(0, 1));
      @(negedge clk);
      sample_valid = 1'b0; hw_start = 1'b0; hw_stop = 1'b0;
      n_checks++; if (bank_wr_en !== '0) $display("FAIL m3_no_extra_write: got %0h expected 0", bank_wr_en); else n_pass++;
      n_checks++; if (state !== S_HOLD || capture_full !== 1'b1) $display("FAIL m3_hold_kept: got %0d/%0b expected 3/1", state, capture_full); else n_pass++;
    end
    handshake(3);
  endtask

  task automatic test_mode1_stop();
    run_capture(1, 200, 1'b1, 0);
    n_checks++; if (write_depth_data !== exp_depth_vec()) $display("FAIL m1_depth: got %0h expected %0h", write_depth_data, exp_depth_vec()); else n_pass++;
    for (int b = 0; b < CH; b++) begin
      n_checks++;
      if (write_depth_data[b*DW +: DW] !== ((b < 6) ? 7'd64 : 7'd8))
        $display("FAIL m1_bank%0d_depth: got %0d expected %0d", b, write_depth_data[b*DW +: DW], (b < 6) ? 64 : 8);
      else n_pass++;
    end
    n_checks++; if (capture_full !== 1'b0) $display("FAIL m1_full: got %0b expected 0", capture_full); else n_pass++;
    handshake(2);
  endtask

  task automatic test_mode1_full();
    run_capture(1, 100000, 1'b1, 0);
    n_checks++; if (capture_full !== 1'b1) $display("FAIL m1f_full: got %0b expected 1", capture_full); else n_pass++;
    n_checks++; if (write_depth_data !== {CH{7'd64}}) $display("FAIL m1f_depth: got %0h expected %0h", write_depth_data, {CH{7'd64}}); else n_pass++;
    handshake(1);
  endtask

  task automatic test_start_stop_same();
    int m;
    m = $urandom_range(0, 3);
    if (state != S_IDLE) begin sw_reset = 1'b1; @(negedge clk); sw_reset = 1'b0; end
    banking_mode = m[BMW-1:0]; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    hw_start = 1'b1; hw_stop = 1'b1; sample_valid = 1'b1;
    @(negedge clk);
    hw_start = 1'b0; hw_stop = 1'b0; sample_valid = 1'b0;
    for (int b = 0; b < CH; b++) exp_depth[b] = 0;
    n_checks++; if (state !== S_HOLD) $display("FAIL ss_state: got %0d expected 3", state); else n_pass++;
    n_checks++; if (write_depth_valid !== 1'b1) $display("FAIL ss_valid: got %0b expected 1", write_depth_valid); else n_pass++;
    n_checks++; if (write_depth_data !== '0) $display("FAIL ss_depth: got %0h expected 0", write_depth_data); else n_pass++;
    n_checks++; if (capture_full !== 1'b0) $display("FAIL ss_full: got %0b expected 0", capture_full); else n_pass++;
    handshake(1);
  endtask

  task automatic test_sw_reset_capture();
    int x0;
    x0 = xfer_cnt;
    run_capture($urandom_range(0, 3), 45, 1'b1, 1);
    n_checks++; if (state !== S_IDLE) $display("FAIL swr_state: got %0d expected 0", state); else n_pass++;
    write_depth_ready = 1'b1;
    repeat (3) @(negedge clk);
    write_depth_ready = 1'b0;
    n_checks++; if (write_depth_valid !== 1'b0 || xfer_cnt !== x0) $display("FAIL swr_no_depth: got %0b/%0d expected 0/%0d", write_depth_valid, xfer_cnt, x0); else n_pass++;
    arm = 1'b1; sw_reset = 1'b1;
    @(negedge clk);
    arm = 1'b0; sw_reset = 1'b0;
    n_checks++; if (state !== S_IDLE) $display("FAIL swr_priority: got %0d expected 0", state); else n_pass++;
    run_capture(0, 10, 1'b1, 0);
    n_checks++; if (write_depth_data !== {{(CH-1)*DW{1'b0}}, 7'd10}) $display("FAIL swr_recapture_depth: got %0h expected %0h", write_depth_data, 7'd10); else n_pass++;
    handshake(0);
  endtask

  task automatic test_sw_reset_hold();
    int x0;
    run_capture($urandom_range(0, 3), 20, 1'b1, 0);
    n_checks++; if (write_depth_valid !== 1'b1) $display("FAIL swrh_valid_before: got %0b expected 1", write_depth_valid); else n_pass++;
    x0 = xfer_cnt;
    sw_reset = 1'b1;
    @(negedge clk);
    sw_reset = 1'b0;
    n_checks++; if (write_depth_valid !== 1'b0) $display("FAIL swrh_valid_drop: got %0b expected 0", write_depth_valid); else n_pass++;
    n_checks++; if (state !== S_IDLE) $display("FAIL swrh_state: got %0d expected 0", state); else n_pass++;
    write_depth_ready = 1'b1;
    repeat (3) @(negedge clk);
    write_depth_ready = 1'b0;
    n_checks++; if (xfer_cnt !== x0) $display("FAIL swrh_no_transfer: got %0d expected %0d", xfer_cnt, x0); else n_pass++;
  endtask

  task automatic test_random_modes();
    int m, n;
    for (int it = 0; it < 3; it++) begin
      m = $urandom_range(0, 3);
      n = $urandom_range(1, BD * (CH >> m) + 10);
      run_capture(m, n, 1'b1, 0);
      n_checks++; if (state !== S_HOLD) $display("FAIL rnd_state: got %0d expected 3", state); else n_pass++;
      n_checks++; if (capture_full !== exp_full) $display("FAIL rnd_full: got %0b expected %0b", capture_full, exp_full); else n_pass++;
      n_checks++; if (write_depth_data !== exp_depth_vec()) $display("FAIL rnd_depth: got %0h expected %0h", write_depth_data, exp_depth_vec()); else n_pass++;
      handshake($urandom_range(0, 5));
    end
  endtask

  initial begin
    adc_reset = 1'b1; arm = 1'b0; sw_reset = 1'b0; hw_start = 1'b0; hw_stop = 1'b0;
    sample_valid = 1'b0; write_depth_ready = 1'b0; readout_done = 1'b0; banking_mode = '0;
    exp_full = 1'b0;
    test_reset();
    test_start_without_arm();
    test_mode0_stop();
    test_back_to_back();
    test_mode3_full();
    test_mode1_stop();
    test_mode1_full();
    test_start_stop_same();
    test_sw_reset_capture();
    test_sw_reset_hold();
    test_random_modes();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

- Capture-side controller for the receive-chain sample buffer, in the ADC clock domain.
- Sequences arm/trigger/stop/full, generates per-bank write strobes and addresses according to the banking mode, and reports per-bank write depth exactly once per capture.
- Sits between the ps-side config CDC outputs and the bank memories; readout is handled elsewhere.

## Interface
Parameters:
- BUFFER_DEPTH, 64, samples per bank (power of 2)
- CHANNELS, rx_pkg::CHANNELS, number of banks/channels (power of 2)
- BMW, $clog2($clog2(CHANNELS+1)), banking-mode width

Ports:
- adc_clk  in  1  clock
- adc_reset  in  1  one clock; reset is synchronous and active-high
- arm  in  1  single-cycle arm pulse (already synchronized)
- banking_mode  in  BMW  active channels = 1<<banking_mode; latched on accepted arm; values >$clog2(CHANNELS) clamp to max
- sw_reset  in  1  pulse; abort to IDLE
- hw_start / hw_stop  in  1 each  hardware trigger / stop
- sample_valid  in  1  all channels present a sample this cycle
- bank_wr_en  out  CHANNELS  per-bank write strobe
- bank_wr_addr  out  CHANNELS*$clog2(BUFFER_DEPTH)  per-bank address
- capture_full  out  1  level, capture ended by full
- write_depth_data  out  CHANNELS*($clog2(BUFFER_DEPTH)+1)  per-bank sample count, bank 0 in LSBs
- write_depth_valid  out 1 / write_depth_ready  in 1  AXIS-style handshake
- readout_done  in  1  pulse from readout side
- state  out  2  IDLE=0, ARMED=1, CAPTURE=2, HOLD=3

## Operation
- IDLE: arm → ARMED, latch mode m. Start/stop/readout_done ignored.
- ARMED: hw_start → CAPTURE. Start+stop in the same cycle → HOLD with zero samples. Arm ignored in every non-IDLE state.
- CAPTURE: each sample_valid cycle writes all active channels and increments a shared pointer p.
  - Width of p: $clog2(BUFFER_DEPTH*CHANNELS)+1.
  - Capacity: CAP = BUFFER_DEPTH*(CHANNELS>>m).
  - Active channel c writes bank c + (p/BUFFER_DEPTH)<<m at address p%BUFFER_DEPTH.
  - hw_stop → HOLD; a sample valid in the stop cycle is NOT written.
  - Write making p==CAP → HOLD, capture_full=1.
- HOLD:
  - On entry, write_depth_valid=1. For bank b, with k=b>>m, data = clamp(p−k*BUFFER_DEPTH, 0, BUFFER_DEPTH).
  - Data is stable until ready. Exactly one transfer per capture.
  - readout_done is ignored until the write_depth transfer completes; afterwards it goes to IDLE.
  - hw_start/hw_stop/sample_valid are ignored.
- sw_reset or adc_reset, any state:
  - Next state IDLE; p=0.
  - write_depth_valid drops even if a transfer is pending (no transfer occurs).
  - capture_full=0; bank_wr_en=0.
- sw_reset has priority over every simultaneous event.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, bank_wr_en=0, bank_wr_addr=0, capture_full=0, write_depth_valid=0, write_depth_data=0.
- Write latency 1: sample_valid at cycle N in CAPTURE → bank_wr_en/addr at N+1. The datapath delays data by one register.
- The hw_start cycle is a transition cycle; the first writable sample is at N+1 after start.
- State update is 1 cycle after the triggering input. capture_full and write_depth_valid rise in the first HOLD cycle.
- capture_full is cleared when HOLD is left.

## Configuration
- CAPTURE_SEQ_AUTO_REARM_EN defined: readout_done in HOLD (after write_depth accepted) → ARMED. The banking mode is retained; p=0 and capture_full is cleared.
- Not defined: HOLD → IDLE, and a new arm is required.

## Test plan
- (CHANNELS=8, BUFFER_DEPTH=64)
- Mode 0: arm, start, 50 valid, stop → bank0 addr 0..49, then bank_wr_en=0; write_depth {bank0=50, others 0}; exactly one transfer; capture_full=0.
- Mode 3: arm, start, continuous valid → after 64 samples, capture_full=1, all banks 64, no 65th write; later hw_start/hw_stop have no effect.
- Mode 1: 200 samples, stop → ch0 uses banks 0,2,4,6 and ch1 uses banks 1,3,5,7; depths banks0–5=64, banks6,7=8. Also run to full: 256 samples per channel, all banks 64.
- hw_start with no arm → state stays IDLE, no writes, no write_depth. Start+stop in the same cycle while ARMED → HOLD with all-zero write_depth and capture_full=0.
- sw_reset after 45 samples in CAPTURE → IDLE next cycle, no write_depth. Re-arm and capture 10 → depth 10 at addresses 0..9. sw_reset in HOLD with ready=0 → valid drops, no transfer.
- write_depth_ready low for 20 cycles → valid/data stable, readout_done ignored. Ready high → one transfer; readout_done → IDLE (ARMED with CAPTURE_SEQ_AUTO_REARM_EN; the next start captures with no new arm).
